// File: rtl/pc_sequencer.sv
// Fetch-stage program counter for MIPS32: next-PC priority mux, exception entry/return
// with a saved EPC, and a circular return-address stack that JAL pushes and JR $ra pops.
module pc_sequencer #(
  parameter int          ADDR_W       = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch,
  input  logic              alu_zero,
  input  logic [ADDR_W-1:0] branch_offset,
  input  logic              jump,
  input  logic              jal,
  input  logic [25:0]       jump_target,
  input  logic              jr,
  input  logic              jr_ra,
  input  logic [ADDR_W-1:0] jr_target,
  input  logic              exception,
  input  logic              eret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] epc,
  output logic              in_exc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] RST_PC   = RESET_VECTOR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] EXC_PC   = EXC_VECTOR[ADDR_W-1:0];
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  top;
  logic [PTR_W-1:0]  top_inc;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] branch_pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] epc_nxt;
  logic              in_exc_nxt;
  logic              push;
  logic              pop;
  logic              underflow_nxt;

  assign pc_plus4  = pc + ADDR_W'(4);
  assign branch_pc = pc_plus4 + (branch_offset << 2);
  assign top_inc   = top + PTR_W'(1);
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == FULL_CNT);

  // A 28-bit PC has no region bits above the 256 MB jump window to carry over.
  generate
    if (ADDR_W > 28) begin : g_jump_region
      assign jump_pc = {pc_plus4[ADDR_W-1:28], jump_target, 2'b00};
    end else begin : g_jump_flat
      assign jump_pc = {jump_target, 2'b00};
    end
  endgenerate

  always_comb begin
    pc_nxt        = pc_plus4;
    epc_nxt       = epc;
    in_exc_nxt    = in_exc;
    push          = 1'b0;
    pop           = 1'b0;
    underflow_nxt = 1'b0;
    if (exception) begin
      pc_nxt = EXC_PC;
      // A nested exception must not lose the original return address.
      if (!in_exc) begin
        epc_nxt    = pc;
        in_exc_nxt = 1'b1;
      end
    end else if (stall) begin
      pc_nxt = pc;
    end else if (eret && in_exc) begin
      pc_nxt     = epc;
      in_exc_nxt = 1'b0;
    end else if (jr) begin
      if (jr_ra && !ras_empty) begin
        pc_nxt = ras_mem[top];
        pop    = 1'b1;
      end else begin
        pc_nxt        = jr_target;
        underflow_nxt = jr_ra;
      end
    end else if (jump) begin
      pc_nxt = jump_pc;
      push   = jal;
    end else if (branch && alu_zero) begin
      pc_nxt = branch_pc;
    end
  end

  // Registered state: PC, exception context and RAS bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= RST_PC;
      epc           <= '0;
      in_exc        <= 1'b0;
      top           <= '0;
      cnt           <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      pc            <= pc_nxt;
      epc           <= epc_nxt;
      in_exc        <= in_exc_nxt;
      ras_underflow <= underflow_nxt;
      if (push) begin
        top <= top_inc;
        if (ras_full) ras_overflow <= 1'b1;
        else          cnt <= cnt + CNT_W'(1);
      end else if (pop) begin
        top <= top - PTR_W'(1);
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Entries carry no reset; validity is tracked by cnt alone. A push when full
  // lands on top+1, which is exactly the oldest slot of the circular buffer.
  always_ff @(posedge clk) begin
    if (push) ras_mem[top_inc] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer at default parameters (32-bit PC, 4-entry RAS).
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, alu_zero, jump, jal, jr, jr_ra, exception, eret;
  logic [31:0] branch_offset, jr_target;
  logic [25:0] jump_target;
  logic [31:0] pc, pc_plus4, epc;
  logic        in_exc, ras_empty, ras_full, ras_overflow, ras_underflow;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .alu_zero(alu_zero),
    .branch_offset(branch_offset), .jump(jump), .jal(jal), .jump_target(jump_target),
    .jr(jr), .jr_ra(jr_ra), .jr_target(jr_target), .exception(exception), .eret(eret),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .in_exc(in_exc), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; alu_zero = 0; jump = 0; jal = 0; jr = 0; jr_ra = 0;
    exception = 0; eret = 0; branch_offset = '0; jr_target = '0; jump_target = '0;
  endtask

  task automatic goto(input logic [31:0] a);
    jr = 1; jr_ra = 0; jr_target = a;
    step();
    jr = 0; jr_target = '0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    total++; if (epc !== 32'h0 || in_exc !== 1'b0) begin bad++; $display("FAIL reset_exc: epc %h in_exc %b want 0 0", epc, in_exc); end
    total++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin bad++; $display("FAIL reset_ras: got %b want 1000", {ras_empty, ras_full, ras_overflow, ras_underflow}); end
    rst_n = 1;
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc = exp_pc + 32'h4;
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL free_run[%0d]: got %h want %h", i, pc, exp_pc); end
    end
    #2 rst_n = 0;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0); end
    rst_n = 1;
  endtask

  task automatic test_branch();
    goto(32'h10);
    branch = 1; alu_zero = 1; branch_offset = 32'hFFFF_FFFC;
    step();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL branch_taken: got %h want %h", pc, 32'h4); end
    branch = 0; alu_zero = 0;
    goto(32'h10);
    branch = 1; alu_zero = 0;
    step();
    total++; if (pc !== 32'h14) begin bad++; $display("FAIL branch_not_taken: got %h want %h", pc, 32'h14); end
    branch = 0; branch_offset = '0;
  endtask

  task automatic test_jal_jr();
    goto(32'h100);
    jump = 1; jal = 1; jump_target = 26'h40;
    step();
    jump = 0; jal = 0;
    total++; if (pc !== 32'h100 || ras_empty !== 1'b0) begin bad++; $display("FAIL jal: pc %h empty %b want 00000100 0", pc, ras_empty); end
    jr = 1; jr_ra = 1; jr_target = 32'h999;
    step();
    jr = 0; jr_ra = 0;
    total++; if (pc !== 32'h104 || ras_empty !== 1'b1) begin bad++; $display("FAIL jr_ra_pop: pc %h empty %b want 00000104 1", pc, ras_empty); end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] pushed [5] = '{32'h108, 32'h404, 32'h444, 32'h484, 32'h4C4};
    for (int i = 0; i < 5; i++) begin
      jump = 1; jal = 1; jump_target = 26'h100 + 26'(i * 16);
      step();
      total++; if (pc !== 32'h400 + 32'(i * 64)) begin bad++; $display("FAIL jal_chain_pc[%0d]: got %h want %h", i, pc, 32'h400 + 32'(i * 64)); end
      if (i == 3) begin
        total++; if (ras_full !== 1'b1 || ras_overflow !== 1'b0) begin bad++; $display("FAIL ras_full_no_ovf: full %b ovf %b want 1 0", ras_full, ras_overflow); end
      end
    end
    jump = 0; jal = 0;
    total++; if (ras_full !== 1'b1 || ras_overflow !== 1'b1) begin bad++; $display("FAIL ras_overflow: full %b ovf %b want 1 1", ras_full, ras_overflow); end
    for (int i = 4; i >= 1; i--) begin
      jr = 1; jr_ra = 1; jr_target = 32'hDEAD_0000;
      step();
      total++; if (pc !== pushed[i]) begin bad++; $display("FAIL ras_pop[%0d]: got %h want %h", i, pc, pushed[i]); end
    end
    total++; if (ras_empty !== 1'b1 || ras_underflow !== 1'b0) begin bad++; $display("FAIL ras_drained: empty %b unf %b want 1 0", ras_empty, ras_underflow); end
    jr_target = 32'h200;
    step();
    jr = 0; jr_ra = 0;
    total++; if (pc !== 32'h200 || ras_underflow !== 1'b1) begin bad++; $display("FAIL underflow: pc %h unf %b want 00000200 1", pc, ras_underflow); end
    step();
    total++; if (pc !== 32'h204 || ras_underflow !== 1'b0 || ras_overflow !== 1'b1) begin bad++; $display("FAIL underflow_pulse: pc %h unf %b ovf %b want 00000204 0 1", pc, ras_underflow, ras_overflow); end
  endtask

  task automatic test_exception();
    goto(32'h50);
    exception = 1; stall = 1;
    step();
    exception = 0; stall = 0;
    total++; if (pc !== 32'h180 || epc !== 32'h50 || in_exc !== 1'b1) begin bad++; $display("FAIL exc_entry: pc %h epc %h in_exc %b want 180 50 1", pc, epc, in_exc); end
    step();
    total++; if (pc !== 32'h184) begin bad++; $display("FAIL exc_handler: got %h want %h", pc, 32'h184); end
    exception = 1;
    step();
    exception = 0;
    total++; if (pc !== 32'h180 || epc !== 32'h50 || in_exc !== 1'b1) begin bad++; $display("FAIL exc_nested: pc %h epc %h in_exc %b want 180 50 1", pc, epc, in_exc); end
    eret = 1;
    step();
    total++; if (pc !== 32'h50 || in_exc !== 1'b0) begin bad++; $display("FAIL eret: pc %h in_exc %b want 50 0", pc, in_exc); end
    step();
    eret = 0;
    total++; if (pc !== 32'h54 || in_exc !== 1'b0) begin bad++; $display("FAIL eret_ignored: pc %h in_exc %b want 54 0", pc, in_exc); end
  endtask

  task automatic test_stall();
    goto(32'h20);
    jump = 1; jal = 1; jump_target = 26'h30; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc !== 32'h20 || ras_empty !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d]: pc %h empty %b want 20 1", i, pc, ras_empty); end
    end
    stall = 0;
    step();
    jump = 0; jal = 0;
    total++; if (pc !== 32'hC0 || ras_empty !== 1'b0) begin bad++; $display("FAIL stall_release: pc %h empty %b want c0 0", pc, ras_empty); end
    jr = 1; jr_ra = 1;
    step();
    jr = 0; jr_ra = 0;
    total++; if (pc !== 32'h24) begin bad++; $display("FAIL stall_push_addr: got %h want %h", pc, 32'h24); end
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFC);
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL pc_plus4_wrap: got %h want %h", pc_plus4, 32'h0); end
    step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL pc_wrap: got %h want %h", pc, 32'h0); end
  endtask

  task automatic test_mid_reset();
    jump = 1; jal = 1; jump_target = 26'h10;
    step();
    jump = 0; jal = 0; exception = 1;
    step();
    exception = 0;
    total++; if (in_exc !== 1'b1 || ras_empty !== 1'b0 || ras_overflow !== 1'b1) begin bad++; $display("FAIL pre_reset_state: in_exc %b empty %b ovf %b want 1 0 1", in_exc, ras_empty, ras_overflow); end
    #2 rst_n = 0;
    #1;
    total++; if (pc !== 32'h0 || epc !== 32'h0 || in_exc !== 1'b0) begin bad++; $display("FAIL mid_reset_exc: pc %h epc %h in_exc %b want 0 0 0", pc, epc, in_exc); end
    total++; if ({ras_empty, ras_full, ras_overflow, ras_underflow} !== 4'b1000) begin bad++; $display("FAIL mid_reset_ras: got %b want 1000", {ras_empty, ras_full, ras_overflow, ras_underflow}); end
    rst_n = 1;
    step();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL post_reset_run: got %h want %h", pc, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jal_jr();
    test_ras_overflow();
    test_exception();
    test_stall();
    test_wrap();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
